spi_param_bank: RTL and testbench
=================================

Name: spi_param_bank

Overview:
- Sits directly downstream of the SPI receiver and consumes its adrs/data/rx_valid output.
- Holds 64 synth parameter bytes in two banks. SPI writes land in a shadow bank.
- A commit command copies the shadow bank into the active bank in one atomic burst.
- The synth engine reads the active bank through a registered read port, so parameter sets change glitch-free.

Parameters:
- N_PARAM, 64, number of parameter bytes per bank (power of two, at most 64)
- CMD_COMMIT, 8'h7F, address of the commit command
- CMD_CLEAR, 8'h7E, address of the clear command
- CLEAR_KEY, 8'hA5, data value required to execute a clear

Ports:
- clk  in  1  system clock; the SPI receiver runs in the same domain
- reset  in  1  synchronous, active-high reset
- adrs  in  8  address byte from the SPI receiver
- data  in  8  data byte from the SPI receiver
- rx_valid  in  1  frame-valid level from the SPI receiver
- rd_adrs  in  6  engine read address into the active bank
- rd_data  out  8  active[rd_adrs], registered
- busy  out  1  high while in COPY or CLEAR
- param_updated  out  1  one-cycle pulse when a commit completes
- err_cnt  out  8  saturating count of rejected frames

Behaviour:
- Frame acceptance:
  - A frame is accepted on the cycle where rx_valid=1 and the registered previous rx_valid=0 (rising-edge detect).
  - adrs and data are sampled on that same cycle.
  - A level held high produces exactly one frame.
- Decode of an accepted frame:
  - adrs < N_PARAM: write data into shadow[adrs].
  - adrs == CMD_COMMIT: commit request; data is ignored.
  - adrs == CMD_CLEAR with data == CLEAR_KEY: clear request.
  - adrs == CMD_CLEAR with any other data, or any other address: rejected, err_cnt += 1, saturating at 255.
- States: IDLE, COPY, CLEAR.
- IDLE: on a commit request go to COPY; on a clear request go to CLEAR.
- COPY:
  - idx runs 0..N_PARAM-1. Shadow is read at idx (registered), and active[idx-1] is written the following cycle.
  - If commit is accepted at cycle T: busy=1 from T+1, last active write at T+N_PARAM+1, param_updated=1 and busy=0 at T+N_PARAM+2, then IDLE.
  - Shadow writes during COPY are performed. Whether a given active entry sees the new value depends on whether its index has already been read. The bench checks only non-overlapping cases.
  - A commit accepted during COPY sets commit_pending. At completion, param_updated still pulses and a new COPY starts the next cycle, so busy stays high. At most one commit is pending.
  - A clear accepted during COPY is rejected (err_cnt += 1).
- CLEAR:
  - Writes 0 to shadow[idx] and active[idx] for idx 0..N_PARAM-1, one index per cycle. busy=1 for N_PARAM cycles.
  - No param_updated pulse.
  - Any frame accepted during CLEAR is rejected (err_cnt += 1).
- Reset:
  - Outputs: rd_data=0, busy=1, param_updated=0, err_cnt=0. commit_pending=0, previous rx_valid register=0.
  - After reset deasserts the FSM enters CLEAR automatically, so both banks read 0 once busy falls.
  - Reset asserted mid-COPY or mid-CLEAR aborts the operation and restarts CLEAR.
  - Reset does not touch the banks directly (RAM-inferable); the automatic CLEAR zeroes them.
- Read port:
  - rd_data = active[rd_adrs] registered, 1-cycle latency, available in every state.
  - During COPY, reading an index already written returns the new value. Reading an index not yet written returns the old value, never a mix.
- Banks are 1-write/1-read dual-port arrays. The active bank's write port is owned solely by the FSM.

Test Plan:
- Reset, release, wait -> busy high exactly 64 cycles after release. Then every rd_adrs 0..63 returns rd_data=0 and err_cnt=0.
- Frames (0x05,0x3C), (0x3F,0xFF) with no commit -> rd_data at 0x05 and 0x3F stays 0x00. Then commit (0x7F,0x00) -> busy for 65 cycles, single param_updated pulse at T+66, rd_data(0x05)=0x3C, rd_data(0x3F)=0xFF.
- rx_valid held high 10 cycles carrying (0x10,0x77) -> exactly one shadow write; after commit rd_data(0x10)=0x77.
- Frames (0x40,0x12), (0x7E,0x00), (0x90,0x01) -> err_cnt=3, banks unchanged. Then 300 bad frames -> err_cnt saturates at 0xFF.
- Commit, then a second commit 10 cycles later -> busy continuous for 2×65 cycles, two param_updated pulses. A clear sent during the first COPY -> err_cnt += 1.
- Load 0x20=0xAA and commit; clear (0x7E,0xA5) -> busy for 64 cycles, rd_data(0x20)=0x00, no param_updated pulse. Reset asserted mid-COPY -> busy stays high and 64 cycles after release all entries read 0.

Source files
------------

// File: rtl/spi_param_bank.sv
// spi_param_bank
// Double-banked store of synth parameter bytes sitting behind the SPI receiver.
// SPI frames write a shadow bank. A commit frame copies the shadow bank into
// the active bank in one burst. The synth engine reads only the active bank,
// so a parameter set always changes as a whole.
//
// Ports:
//   clk           system clock, shared with the SPI receiver
//   reset         synchronous, active-high reset
//   adrs, data    address/data bytes from the SPI receiver
//   rx_valid      frame-valid level; a rising edge marks one frame
//   rd_adrs       engine read address into the active bank
//   rd_data       active[rd_adrs], one cycle latency
//   busy          high while copying or clearing
//   param_updated one-cycle pulse when a commit completes
//   err_cnt       saturating count of rejected frames
module spi_param_bank #(
  parameter int         N_PARAM    = 64,
  parameter logic [7:0] CMD_COMMIT = 8'h7F,
  parameter logic [7:0] CMD_CLEAR  = 8'h7E,
  parameter logic [7:0] CLEAR_KEY  = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] adrs,
  input  logic [7:0] data,
  input  logic       rx_valid,
  input  logic [5:0] rd_adrs,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       param_updated,
  output logic [7:0] err_cnt
);

  localparam logic [7:0] N_PARAM_B = 8'(N_PARAM);
  localparam logic [6:0] IDX_LAST  = 7'(N_PARAM - 1);
  localparam logic [6:0] IDX_END   = 7'(N_PARAM);

  typedef enum logic [1:0] {IDLE, COPY, CLEAR} state_t;

  state_t     state_q;
  logic [6:0] idx_q;
  logic       rxValidPrev_q;
  logic       commitPending_q;
  logic       busy_q;
  logic       paramUpdated_q;
  logic [7:0] errCnt_q;
  logic [7:0] rdData_q;
  logic [7:0] shadowRd_q;

  logic [7:0] shadowMem [64];
  logic [7:0] activeMem [64];

  logic       frameValid;
  logic       isWrite;
  logic       isCommit;
  logic       isClear;
  logic       writeAccept;
  logic       commitNow;
  logic       clearNow;
  logic       reject;

  logic       shadowWe;
  logic [5:0] shadowWa;
  logic [7:0] shadowWd;
  logic       activeWe;
  logic [5:0] activeWa;
  logic [7:0] activeWd;

  // Frame decode: one frame per rising edge of rx_valid. Clears are only
  // honoured from IDLE, and nothing is honoured while clearing.
  always_comb begin
    frameValid  = rx_valid & ~rxValidPrev_q;
    isWrite     = (adrs < N_PARAM_B);
    isCommit    = (adrs == CMD_COMMIT);
    isClear     = (adrs == CMD_CLEAR) && (data == CLEAR_KEY);
    writeAccept = frameValid && isWrite && (state_q != CLEAR);
    commitNow   = frameValid && isCommit && (state_q != CLEAR);
    clearNow    = frameValid && isClear && (state_q == IDLE);
    if (state_q == CLEAR) begin
      reject = frameValid;
    end else begin
      reject = frameValid && !(isWrite || isCommit || (isClear && state_q == IDLE));
    end
  end

  // Bank write ports. The shadow port is shared between SPI writes and the
  // clear sweep; they never collide because SPI writes are refused in CLEAR.
  // During COPY the active write trails the shadow read by one cycle.
  always_comb begin
    shadowWe = !reset && ((state_q == CLEAR) || writeAccept);
    shadowWa = (state_q == CLEAR) ? idx_q[5:0] : adrs[5:0];
    shadowWd = (state_q == CLEAR) ? 8'h00 : data;
    activeWe = !reset && ((state_q == CLEAR) || (state_q == COPY && idx_q != 7'd0));
    activeWa = (state_q == CLEAR) ? idx_q[5:0] : 6'(idx_q - 7'd1);
    activeWd = (state_q == CLEAR) ? 8'h00 : shadowRd_q;
  end

  // Shadow bank storage plus its registered read port feeding the copy.
  always_ff @(posedge clk) begin
    if (shadowWe) begin
      shadowMem[shadowWa] <= shadowWd;
    end
    shadowRd_q <= shadowMem[idx_q[5:0]];
  end

  // Active bank storage; its write port belongs to the FSM alone.
  always_ff @(posedge clk) begin
    if (activeWe) begin
      activeMem[activeWa] <= activeWd;
    end
  end

  // Engine read port, available in every state.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdData_q <= 8'h00;
    end else begin
      rdData_q <= activeMem[rd_adrs];
    end
  end

  // Control FSM. Reset parks it in CLEAR so both banks are zeroed once reset
  // releases. A commit that completes with another commit pending (or
  // arriving that same cycle) restarts COPY immediately, keeping busy high.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= CLEAR;
      idx_q           <= 7'd0;
      busy_q          <= 1'b1;
      paramUpdated_q  <= 1'b0;
      commitPending_q <= 1'b0;
      errCnt_q        <= 8'h00;
      rxValidPrev_q   <= 1'b0;
    end else begin
      rxValidPrev_q  <= rx_valid;
      paramUpdated_q <= 1'b0;
      if (reject && errCnt_q != 8'hFF) begin
        errCnt_q <= errCnt_q + 8'd1;
      end
      case (state_q)
        IDLE: begin
          idx_q <= 7'd0;
          if (commitNow) begin
            state_q <= COPY;
            busy_q  <= 1'b1;
          end else if (clearNow) begin
            state_q <= CLEAR;
            busy_q  <= 1'b1;
          end
        end
        COPY: begin
          if (idx_q == IDX_END) begin
            paramUpdated_q <= 1'b1;
            idx_q          <= 7'd0;
            if (commitPending_q || commitNow) begin
              state_q         <= COPY;
              busy_q          <= 1'b1;
              commitPending_q <= commitPending_q && commitNow;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            idx_q <= idx_q + 7'd1;
            if (commitNow) begin
              commitPending_q <= 1'b1;
            end
          end
        end
        CLEAR: begin
          if (idx_q == IDX_LAST) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            idx_q   <= 7'd0;
          end else begin
            idx_q <= idx_q + 7'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          idx_q   <= 7'd0;
        end
      endcase
    end
  end

  assign rd_data       = rdData_q;
  assign busy          = busy_q;
  assign param_updated = paramUpdated_q;
  assign err_cnt       = errCnt_q;

endmodule

// File: tb/tb_spi_param_bank.sv
// tb_spi_param_bank
// Directed bench for spi_param_bank: reset sweep, shadow isolation, level
// hold, frame rejection and saturation, back-to-back commits, clear, and
// reset in the middle of a copy.
module tb_spi_param_bank;

  logic       clk;
  logic       reset;
  logic [7:0] adrs;
  logic [7:0] data;
  logic       rx_valid;
  logic [5:0] rd_adrs;
  logic [7:0] rd_data;
  logic       busy;
  logic       param_updated;
  logic [7:0] err_cnt;

  int checks;
  int errors;

  spi_param_bank dut (
    .clk           (clk),
    .reset         (reset),
    .adrs          (adrs),
    .data          (data),
    .rx_valid      (rx_valid),
    .rd_adrs       (rd_adrs),
    .rd_data       (rd_data),
    .busy          (busy),
    .param_updated (param_updated),
    .err_cnt       (err_cnt)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net in case something stalls beyond the bounded waits
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // One frame: rx_valid rises at a falling edge, is accepted at the next
  // rising edge, and drops again at the following falling edge.
  task automatic sendFrame(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    adrs     = a;
    data     = d;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic readAt(input logic [5:0] a, output logic [7:0] d);
    @(negedge clk);
    rd_adrs = a;
    @(negedge clk);
    d = rd_data;
  endtask

  // Counts the run of busy cycles starting at the current falling edge and
  // any param_updated pulses seen until a few cycles after busy drops.
  task automatic waitIdle(output int busyRun, output int pulses, output int firstPulse);
    busyRun    = 0;
    pulses     = 0;
    firstPulse = -1;
    for (int c = 0; c < 300; c++) begin
      if (param_updated === 1'b1) begin
        pulses++;
        if (firstPulse < 0) firstPulse = c;
      end
      if (busy === 1'b1 && busyRun == c) busyRun++;
      if (c >= busyRun + 3) break;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    int busyRun, pulses, firstPulse;
    logic [7:0] d;
    @(negedge clk);
    reset    = 1'b1;
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_busy: got %b expected 1", busy);
    end
    checks++;
    if (rd_data !== 8'h00 || err_cnt !== 8'h00 || param_updated !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got rd=%h err=%h pu=%b expected 00 00 0",
               rd_data, err_cnt, param_updated);
    end
    reset = 1'b0;
    waitIdle(busyRun, pulses, firstPulse);
    checks++;
    if (busyRun != 64) begin
      errors++;
      $display("[TB] FAIL reset_clear_len: got %0d expected 64", busyRun);
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("[TB] FAIL reset_no_pulse: got %0d expected 0", pulses);
    end
    for (int i = 0; i < 64; i++) begin
      readAt(6'(i), d);
      checks++;
      if (d !== 8'h00) begin
        errors++;
        $display("[TB] FAIL reset_zero[%0d]: got %h expected 00", i, d);
      end
    end
    checks++;
    if (err_cnt !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_errcnt: got %h expected 00", err_cnt);
    end
  endtask

  task automatic test_shadow_isolation;
    int busyRun, pulses, firstPulse;
    logic [7:0] d;
    sendFrame(8'h05, 8'h3C);
    sendFrame(8'h3F, 8'hFF);
    readAt(6'h05, d);
    checks++;
    if (d !== 8'h00) begin
      errors++;
      $display("[TB] FAIL precommit_05: got %h expected 00", d);
    end
    readAt(6'h3F, d);
    checks++;
    if (d !== 8'h00) begin
      errors++;
      $display("[TB] FAIL precommit_3F: got %h expected 00", d);
    end
    sendFrame(8'h7F, 8'h00);
    waitIdle(busyRun, pulses, firstPulse);
    checks++;
    if (busyRun != 65) begin
      errors++;
      $display("[TB] FAIL commit_busy_len: got %0d expected 65", busyRun);
    end
    checks++;
    if (pulses != 1 || firstPulse != 65) begin
      errors++;
      $display("[TB] FAIL commit_pulse: got count %0d at %0d expected 1 at 65", pulses, firstPulse);
    end
    readAt(6'h05, d);
    checks++;
    if (d !== 8'h3C) begin
      errors++;
      $display("[TB] FAIL commit_05: got %h expected 3c", d);
    end
    readAt(6'h3F, d);
    checks++;
    if (d !== 8'hFF) begin
      errors++;
      $display("[TB] FAIL commit_3F: got %h expected ff", d);
    end
  endtask

  task automatic test_held_level;
    int busyRun, pulses, firstPulse;
    logic [7:0] d;
    @(negedge clk);
    adrs     = 8'h10;
    data     = 8'h77;
    rx_valid = 1'b1;
    @(negedge clk);
    data = 8'h55;
    repeat (9) @(negedge clk);
    rx_valid = 1'b0;
    sendFrame(8'h7F, 8'h00);
    waitIdle(busyRun, pulses, firstPulse);
    readAt(6'h10, d);
    checks++;
    if (d !== 8'h77) begin
      errors++;
      $display("[TB] FAIL held_level_10: got %h expected 77", d);
    end
    checks++;
    if (err_cnt !== 8'h00) begin
      errors++;
      $display("[TB] FAIL held_level_errcnt: got %h expected 00", err_cnt);
    end
  endtask

  task automatic test_reject;
    int busyRun, pulses, firstPulse;
    logic [7:0] d;
    sendFrame(8'h40, 8'h12);
    sendFrame(8'h7E, 8'h00);
    sendFrame(8'h90, 8'h01);
    @(negedge clk);
    checks++;
    if (err_cnt !== 8'h03) begin
      errors++;
      $display("[TB] FAIL reject_count: got %h expected 03", err_cnt);
    end
    sendFrame(8'h7F, 8'h00);
    waitIdle(busyRun, pulses, firstPulse);
    readAt(6'h00, d);
    checks++;
    if (d !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reject_bank_00: got %h expected 00", d);
    end
    readAt(6'h10, d);
    checks++;
    if (d !== 8'h77) begin
      errors++;
      $display("[TB] FAIL reject_bank_10: got %h expected 77", d);
    end
  endtask

  task automatic test_back_to_back;
    int busyRun, pulses, pulseA, pulseB;
    busyRun = 0;
    pulses  = 0;
    pulseA  = -1;
    pulseB  = -1;
    sendFrame(8'h7F, 8'h00);
    for (int c = 0; c < 200; c++) begin
      if (busy === 1'b1 && busyRun == c) busyRun++;
      if (param_updated === 1'b1) begin
        pulses++;
        if (pulseA < 0) pulseA = c;
        else if (pulseB < 0) pulseB = c;
      end
      if (c == 2) begin
        adrs     = 8'h7E;
        data     = 8'hA5;
        rx_valid = 1'b1;
      end
      if (c == 3) rx_valid = 1'b0;
      if (c == 10) begin
        adrs     = 8'h7F;
        data     = 8'h00;
        rx_valid = 1'b1;
      end
      if (c == 11) rx_valid = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (busyRun != 130) begin
      errors++;
      $display("[TB] FAIL b2b_busy_len: got %0d expected 130", busyRun);
    end
    checks++;
    if (pulses != 2 || pulseA != 65 || pulseB != 130) begin
      errors++;
      $display("[TB] FAIL b2b_pulses: got %0d at %0d,%0d expected 2 at 65,130",
               pulses, pulseA, pulseB);
    end
    checks++;
    if (err_cnt !== 8'h04) begin
      errors++;
      $display("[TB] FAIL b2b_clear_reject: got %h expected 04", err_cnt);
    end
  endtask

  task automatic test_saturation;
    for (int i = 0; i < 250; i++) sendFrame(8'h90, 8'h01);
    @(negedge clk);
    checks++;
    if (err_cnt !== 8'hFE) begin
      errors++;
      $display("[TB] FAIL sat_partial: got %h expected fe", err_cnt);
    end
    for (int i = 0; i < 50; i++) sendFrame(8'h90, 8'h01);
    @(negedge clk);
    checks++;
    if (err_cnt !== 8'hFF) begin
      errors++;
      $display("[TB] FAIL sat_final: got %h expected ff", err_cnt);
    end
  endtask

  task automatic test_clear;
    int busyRun, pulses, firstPulse;
    logic [7:0] d;
    sendFrame(8'h20, 8'hAA);
    sendFrame(8'h7F, 8'h00);
    waitIdle(busyRun, pulses, firstPulse);
    readAt(6'h20, d);
    checks++;
    if (d !== 8'hAA) begin
      errors++;
      $display("[TB] FAIL clear_pre_20: got %h expected aa", d);
    end
    sendFrame(8'h7E, 8'hA5);
    waitIdle(busyRun, pulses, firstPulse);
    checks++;
    if (busyRun != 64) begin
      errors++;
      $display("[TB] FAIL clear_busy_len: got %0d expected 64", busyRun);
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("[TB] FAIL clear_no_pulse: got %0d expected 0", pulses);
    end
    readAt(6'h20, d);
    checks++;
    if (d !== 8'h00) begin
      errors++;
      $display("[TB] FAIL clear_20: got %h expected 00", d);
    end
    readAt(6'h05, d);
    checks++;
    if (d !== 8'h00) begin
      errors++;
      $display("[TB] FAIL clear_05: got %h expected 00", d);
    end
    sendFrame(8'h7F, 8'h00);
    waitIdle(busyRun, pulses, firstPulse);
    readAt(6'h3F, d);
    checks++;
    if (d !== 8'h00) begin
      errors++;
      $display("[TB] FAIL clear_shadow_3F: got %h expected 00", d);
    end
    checks++;
    if (err_cnt !== 8'hFF) begin
      errors++;
      $display("[TB] FAIL clear_errcnt: got %h expected ff", err_cnt);
    end
  endtask

  task automatic test_reset_mid_copy;
    int busyRun, pulses, firstPulse;
    int nonZero;
    logic [7:0] d;
    sendFrame(8'h01, 8'h99);
    sendFrame(8'h7F, 8'h00);
    repeat (20) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || err_cnt !== 8'h00) begin
      errors++;
      $display("[TB] FAIL midcopy_reset: got busy=%b err=%h expected 1 00", busy, err_cnt);
    end
    reset = 1'b0;
    waitIdle(busyRun, pulses, firstPulse);
    checks++;
    if (busyRun != 64 || pulses != 0) begin
      errors++;
      $display("[TB] FAIL midcopy_clear: got busy %0d pulses %0d expected 64 0", busyRun, pulses);
    end
    nonZero = 0;
    for (int i = 0; i < 64; i++) begin
      readAt(6'(i), d);
      if (d !== 8'h00) nonZero++;
    end
    checks++;
    if (nonZero != 0) begin
      errors++;
      $display("[TB] FAIL midcopy_zero: got %0d nonzero entries expected 0", nonZero);
    end
  endtask

  // Test sequence
  initial begin
    checks   = 0;
    errors   = 0;
    reset    = 1'b1;
    rx_valid = 1'b0;
    adrs     = 8'h00;
    data     = 8'h00;
    rd_adrs  = 6'h00;
    test_reset;
    test_shadow_isolation;
    test_held_level;
    test_reject;
    test_back_to_back;
    test_saturation;
    test_clear;
    test_reset_mid_copy;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
